// File: rtl/daq_file_rd_sm.sv
// -----------------------------------------------------------------------------
// daq_file_rd_sm
//
// Reader side of the DAQ circular-file scheme kept in RAM. A file_read request
// fetches the six-word file descriptor over the shared bus-master interface.
// If the file holds unread data, one sample is read from rd_ptr. rd_ptr is then
// advanced by the sample size and wraps back to START once it passes END.
// Finally STATUS and RD_PTR are written back to the descriptor.
//
// Ports
//   wb_clk, wb_rst   clock, asynchronous active-high reset
//   file_num         descriptor index, sampled when a request is accepted
//   file_read        request pulse, only honoured in IDLE
//   file_read_data   right-justified, zero-extended sample, valid with file_done
//   file_done        one-cycle completion pulse (data, empty or error)
//   file_empty       qualifies file_done: nothing unread in the file
//   file_error       qualifies file_done: CONTROL size field was 2'b11
//   file_active      high from request accept through the file_done cycle
//   address, start, selection, write, data_wr   bus-master request side
//   data_rd, active  bus-master response side
//
// Bus handshake (start/active): a request state drives address, selection,
// write and data_wr and raises start. Once the master reports active=1 the FSM
// moves to the matching _DONE state. That state drops start (and write) but
// keeps address/data stable. When active falls, read data is taken from
// data_rd and the FSM moves on. Exactly one transfer happens per request state.
// -----------------------------------------------------------------------------
module daq_file_rd_sm #(
  parameter int              dw              = 32,
  parameter int              aw              = 32,
  parameter logic [aw-1:0]   FILE_TABLE_BASE = '0,
  parameter logic [aw-1:0]   FILE_STRIDE     = aw'(32'h20)
) (
  input  logic          wb_clk,
  input  logic          wb_rst,
  input  logic [7:0]    file_num,
  input  logic          file_read,
  output logic [31:0]   file_read_data,
  output logic          file_done,
  output logic          file_empty,
  output logic          file_error,
  output logic          file_active,
  output logic [aw-1:0] address,
  output logic          start,
  output logic [3:0]    selection,
  output logic          write,
  output logic [dw-1:0] data_wr,
  input  logic [dw-1:0] data_rd,
  input  logic          active
);

  localparam logic [aw-1:0] OFF_START   = aw'(32'h00);
  localparam logic [aw-1:0] OFF_END     = aw'(32'h04);
  localparam logic [aw-1:0] OFF_RDPTR   = aw'(32'h08);
  localparam logic [aw-1:0] OFF_WRPTR   = aw'(32'h0C);
  localparam logic [aw-1:0] OFF_STATUS  = aw'(32'h10);
  localparam logic [aw-1:0] OFF_CONTROL = aw'(32'h14);

  // Each bus request state is encoded immediately before its _DONE state.
  // The shared request handler relies on that ordering.
  typedef enum logic [4:0] {
    S_IDLE,
    S_RD_START,   S_RD_START_DONE,
    S_RD_END,     S_RD_END_DONE,
    S_RD_RDPTR,   S_RD_RDPTR_DONE,
    S_RD_WRPTR,   S_RD_WRPTR_DONE,
    S_RD_STATUS,  S_RD_STATUS_DONE,
    S_RD_CONTROL, S_RD_CONTROL_DONE,
    S_CHECK,
    S_RD_DATA,    S_RD_DATA_DONE,
    S_UPDATE,
    S_WR_STATUS,  S_WR_STATUS_DONE,
    S_WR_RDPTR,   S_WR_RDPTR_DONE,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [aw-1:0] base_q, base_d;
  logic [aw-1:0] start_addr_q, start_addr_d;
  logic [aw-1:0] end_addr_q, end_addr_d;
  logic [aw-1:0] rd_ptr_q, rd_ptr_d;
  logic [aw-1:0] wr_ptr_q, wr_ptr_d;
  logic [dw-1:0] status_q, status_d;
  logic [1:0]    size_q, size_d;
  logic [31:0]   data_q, data_d;
  logic          empty_q, empty_d;
  logic          error_q, error_d;

  logic [aw-1:0] incr;
  logic [aw-1:0] rd_next;

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state_q      <= S_IDLE;
      base_q       <= '0;
      start_addr_q <= '0;
      end_addr_q   <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      status_q     <= '0;
      size_q       <= '0;
      data_q       <= '0;
      empty_q      <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      start_addr_q <= start_addr_d;
      end_addr_q   <= end_addr_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      status_q     <= status_d;
      size_q       <= size_d;
      data_q       <= data_d;
      empty_q      <= empty_d;
      error_q      <= error_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    start_addr_d = start_addr_q;
    end_addr_d   = end_addr_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    status_d     = status_q;
    size_d       = size_q;
    data_d       = data_q;
    empty_d      = empty_q;
    error_d      = error_q;
    address      = '0;
    selection    = 4'h0;
    start        = 1'b0;
    write        = 1'b0;
    data_wr      = '0;
    incr         = '0;
    rd_next      = '0;

    // Address and lanes stay stable across each request/_DONE pair.
    case (state_q)
      S_RD_START,   S_RD_START_DONE:   begin address = base_q + OFF_START;   selection = 4'hF; end
      S_RD_END,     S_RD_END_DONE:     begin address = base_q + OFF_END;     selection = 4'hF; end
      S_RD_RDPTR,   S_RD_RDPTR_DONE:   begin address = base_q + OFF_RDPTR;   selection = 4'hF; end
      S_RD_WRPTR,   S_RD_WRPTR_DONE:   begin address = base_q + OFF_WRPTR;   selection = 4'hF; end
      S_RD_STATUS,  S_RD_STATUS_DONE:  begin address = base_q + OFF_STATUS;  selection = 4'hF; end
      S_RD_CONTROL, S_RD_CONTROL_DONE: begin address = base_q + OFF_CONTROL; selection = 4'hF; end
      S_RD_DATA,    S_RD_DATA_DONE:    begin address = {rd_ptr_q[aw-1:2], 2'b00}; selection = 4'hF; end
      S_WR_STATUS,  S_WR_STATUS_DONE:  begin address = base_q + OFF_STATUS;  selection = 4'hF; end
      S_WR_RDPTR,   S_WR_RDPTR_DONE:   begin address = base_q + OFF_RDPTR;   selection = 4'hF; end
      default: ;
    endcase

    case (state_q)
      S_IDLE: begin
        if (file_read) begin
          state_d      = S_RD_START;
          base_d       = FILE_TABLE_BASE + FILE_STRIDE * {{(aw-8){1'b0}}, file_num};
          // Nothing from a previous request may leak into this one.
          start_addr_d = '0;
          end_addr_d   = '0;
          rd_ptr_d     = '0;
          wr_ptr_d     = '0;
          status_d     = '0;
          size_d       = '0;
          data_d       = '0;
          empty_d      = 1'b0;
          error_d      = 1'b0;
        end
      end

      S_RD_START, S_RD_END, S_RD_RDPTR, S_RD_WRPTR,
      S_RD_STATUS, S_RD_CONTROL, S_RD_DATA: begin
        start = 1'b1;
        if (active) state_d = state_e'(state_q + 5'd1);
      end

      S_RD_START_DONE:   if (!active) begin start_addr_d = data_rd[aw-1:0]; state_d = S_RD_END;     end
      S_RD_END_DONE:     if (!active) begin end_addr_d   = data_rd[aw-1:0]; state_d = S_RD_RDPTR;   end
      S_RD_RDPTR_DONE:   if (!active) begin rd_ptr_d     = data_rd[aw-1:0]; state_d = S_RD_WRPTR;   end
      S_RD_WRPTR_DONE:   if (!active) begin wr_ptr_d     = data_rd[aw-1:0]; state_d = S_RD_STATUS;  end
      S_RD_STATUS_DONE:  if (!active) begin status_d     = data_rd;         state_d = S_RD_CONTROL; end
      S_RD_CONTROL_DONE: if (!active) begin size_d       = data_rd[1:0];    state_d = S_CHECK;      end

      S_CHECK: begin
        if (size_q == 2'b11) begin
          error_d = 1'b1;
          state_d = S_DONE;
        end else if ((rd_ptr_q == wr_ptr_q) && !status_q[0]) begin
          // Equal pointers with WRAP set mean a full file, which is readable.
          empty_d = 1'b1;
          data_d  = '0;
          state_d = S_DONE;
        end else begin
          state_d = S_RD_DATA;
        end
      end

      S_RD_DATA_DONE: begin
        if (!active) begin
          case (size_q)
            2'b00:   data_d = data_rd[31:0];
            2'b01:   data_d = {16'h0000, data_rd[{rd_ptr_q[1], 4'b0000} +: 16]};
            default: data_d = {24'h000000, data_rd[{rd_ptr_q[1:0], 3'b000} +: 8]};
          endcase
          state_d = S_UPDATE;
        end
      end

      S_UPDATE: begin
        case (size_q)
          2'b00:   incr = aw'(4);
          2'b01:   incr = aw'(2);
          default: incr = aw'(1);
        endcase
        rd_next = rd_ptr_q + incr;
        if (rd_next > end_addr_q) begin
          rd_ptr_d    = start_addr_q;
          status_d[0] = 1'b0;
        end else begin
          rd_ptr_d = rd_next;
        end
        state_d = S_WR_STATUS;
      end

      S_WR_STATUS: begin
        start   = 1'b1;
        write   = 1'b1;
        data_wr = status_q;
        if (active) state_d = S_WR_STATUS_DONE;
      end
      S_WR_STATUS_DONE: begin
        data_wr = status_q;
        if (!active) state_d = S_WR_RDPTR;
      end
      S_WR_RDPTR: begin
        start   = 1'b1;
        write   = 1'b1;
        data_wr = dw'(rd_ptr_q);
        if (active) state_d = S_WR_RDPTR_DONE;
      end
      S_WR_RDPTR_DONE: begin
        data_wr = dw'(rd_ptr_q);
        if (!active) state_d = S_DONE;
      end

      // A request arriving in this cycle is dropped, not queued.
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign file_done      = (state_q == S_DONE);
  assign file_empty     = file_done & empty_q;
  assign file_error     = file_done & error_q;
  assign file_read_data = file_done ? data_q : 32'h0;
  assign file_active    = (state_q != S_IDLE);

endmodule
